semaforo_peatonal: RTL and testbench
====================================

Name: semaforo_peatonal

Overview:
- Pedestrian-side companion to the vehicle traffic-light controller `semaforo`.
- Debounces the raw crossing button and sends a single-cycle `pulsador` request to `semaforo`.
- Watches the vehicle lights (`rojo`/`amarillo`/`verde`/`blanco`) and drives the pedestrian walk/stop lamps, the wait lamp and a countdown.
- Enforces a safety interlock: pedestrian green is never shown unless vehicles hold red.

Parameters:
- DEBOUNCE, 4: consecutive stable synchronised samples required to accept a new button level.
- WALK_CYCLES, 8: cycles of steady pedestrian green.
- FLASH_CYCLES, 6: cycles of flashing pedestrian green after the walk phase.
- BLINK_HALF, 1: cycles per half-period of the flash.
- CW, 8: width of `cuenta`. Must satisfy WALK_CYCLES+FLASH_CYCLES ≤ 2^CW.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- boton, input, 1: raw pedestrian button, asynchronous, may bounce.
- rojo, input, 1: vehicle red, from `semaforo`.
- amarillo, input, 1: vehicle amber, from `semaforo`.
- verde, input, 1: vehicle green, from `semaforo`.
- blanco, input, 1: pedestrian-phase authorisation, from `semaforo`.
- pulsador, output, 1: one-cycle request pulse to `semaforo`.
- peaton_verde, output, 1: pedestrian walk lamp.
- peaton_rojo, output, 1: pedestrian stop lamp.
- espera, output, 1: "request registered" wait lamp.
- cuenta, output, CW: walk+flash cycles remaining.
- falla, output, 1: sticky interlock-violation flag.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - Outputs: `pulsador`=0, `peaton_verde`=0, `peaton_rojo`=1, `espera`=0, `cuenta`=0, `falla`=0.
  - Internal: state=ESPERA, pending latch cleared, debounced level=0.
  - Reset mid-walk forces pedestrian red immediately, with no clock edge needed.
- Button path:
  - 2-FF synchroniser, then a stability counter.
  - The debounced level changes only after DEBOUNCE consecutive samples differ from it.
  - A press event is a 0→1 transition of the debounced level, so bounces shorter than DEBOUNCE produce no event.
  - Latency from the first edge sampling `boton`=1 (held high) to `pulsador`=1: DEBOUNCE+3 edges.
- `pulsador`: registered; high exactly one cycle per accepted request; never high two cycles in a row.
- FSM states:
  - ESPERA: `peaton_rojo`=1.
    - Press event, or pending latch set → `pulsador`=1 next cycle, go to SOLICITUD, clear the latch.
  - SOLICITUD: `peaton_rojo`=1, `espera`=1.
    - Further presses are ignored; no new pulse.
    - Go to CRUCE on the edge that samples `rojo`=1, `blanco`=1, `verde`=0, `amarillo`=0.
  - CRUCE: `peaton_verde`=1, `peaton_rojo`=0.
    - `cuenta` loads WALK_CYCLES+FLASH_CYCLES-1 on entry and decrements every cycle.
    - After WALK_CYCLES cycles, go to PARPADEO.
  - PARPADEO: `peaton_rojo`=0.
    - `peaton_verde` starts at 1 and toggles every BLINK_HALF cycles.
    - `cuenta` keeps decrementing and reaches 0 in the last cycle.
    - After FLASH_CYCLES cycles, go to DESPEJE.
  - DESPEJE: `peaton_rojo`=1, `cuenta`=0.
    - Go to ESPERA on the first edge sampling `blanco`=0. This prevents re-serving the same authorisation.
- Interlock (CRUCE or PARPADEO):
  - Violation: any edge sampling `rojo`=0, `verde`=1 or `amarillo`=1.
  - Response next cycle: go to DESPEJE, `peaton_verde`=0, `peaton_rojo`=1, `cuenta`=0, `falla`=1.
  - `falla` stays set until reset.
  - `blanco` falling early is not a fault; it likewise goes to DESPEJE next cycle.
- Presses during CRUCE, PARPADEO or DESPEJE:
  - Set the pending latch (one level only).
  - The latch is served on ESPERA entry, so `pulsador` rises one cycle after ESPERA is entered.
- Simultaneous events:
  - A press on the same edge as SOLICITUD→CRUCE is absorbed; the latch is not set.
  - Violation takes priority over phase-timer expiry.
- `peaton_verde` and `peaton_rojo` are never both 1, and never both 0 outside PARPADEO.

Decomposition:
- Package `semaforo_pkg`:
  - State enum: ESPERA, SOLICITUD, CRUCE, PARPADEO, DESPEJE.
  - Default timing constants shared with `semaforo`.
- Sub-module `antirrebote`: synchroniser plus stability counter, parameter DEBOUNCE; outputs debounced level and a one-cycle press event.

Test Plan:
- Press (defaults): `boton`=1 held 10 cycles from reset idle → `pulsador`=1 for exactly 1 cycle on edge 7; `espera`=1 from the next cycle.
- Bounce: `boton` toggled 1,0,1,0 every cycle, then held 0 → no `pulsador`, no `espera`, state stays ESPERA.
- Walk cycle: in SOLICITUD, drive `rojo`=1, `blanco`=1 → `peaton_verde`=1 for 8 cycles with `cuenta` 13→6, then flashing 1,0,1,0,1,0 with `cuenta` 5→0, then `peaton_rojo`=1; after `blanco`=0, state is ESPERA.
- Interlock: during CRUCE with `cuenta`=10, drive `verde`=1 → next cycle `peaton_verde`=0, `peaton_rojo`=1, `falla`=1; `falla` stays 1 until `rst`=0.
- Queued request: press during PARPADEO → no pulse then; `pulsador`=1 in the cycle after ESPERA entry (after `blanco` falls); `espera`=1 afterwards.
- Reset mid-walk: `rst`=0 during CRUCE, between clock edges → `peaton_rojo`=1, `peaton_verde`=0, `cuenta`=0 immediately; after release, state is ESPERA with no pending request.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared types and default timing for the vehicle controller and its
// pedestrian-side companion.
package semaforo_pkg;

    // Pedestrian-side phases.
    typedef enum logic [2:0] {
        ESPERA    = 3'd0,
        SOLICITUD = 3'd1,
        CRUCE     = 3'd2,
        PARPADEO  = 3'd3,
        DESPEJE   = 3'd4
    } estado_t;

    // Default timing constants.
    localparam int DEF_DEBOUNCE     = 4;
    localparam int DEF_WALK_CYCLES  = 8;
    localparam int DEF_FLASH_CYCLES = 6;
    localparam int DEF_BLINK_HALF   = 1;
    localparam int DEF_CW           = 8;

    // Vehicles are not safely stopped unless red alone is lit.
    function automatic logic viola_enclavamiento(input logic rojo,
                                                 input logic amarillo,
                                                 input logic verde);
        return !rojo || amarillo || verde;
    endfunction

endpackage

// File: rtl/antirrebote.sv
// Button conditioner: two-flop synchroniser followed by a stability
// counter; emits the debounced level and a one-cycle rising-edge event.
module antirrebote
    import semaforo_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic boton_i,
    output logic nivel_o,
    output logic pulsacion_o
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic             sinc1_q, sinc2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nivel_q, nivel_d;
    logic             puls_q, puls_d;

    // Accept a new level only after DEBOUNCE consecutive differing samples.
    always_comb begin
        cnt_d   = cnt_q;
        nivel_d = nivel_q;
        puls_d  = 1'b0;
        if (sinc2_q != nivel_q) begin
            if (cnt_q == CNT_MAX) begin
                nivel_d = sinc2_q;
                cnt_d   = '0;
                puls_d  = sinc2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchroniser and debounce state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sinc1_q <= 1'b0;
            sinc2_q <= 1'b0;
            cnt_q   <= '0;
            nivel_q <= 1'b0;
            puls_q  <= 1'b0;
        end else begin
            sinc1_q <= boton_i;
            sinc2_q <= sinc1_q;
            cnt_q   <= cnt_d;
            nivel_q <= nivel_d;
            puls_q  <= puls_d;
        end
    end

    assign nivel_o     = nivel_q;
    assign pulsacion_o = puls_q;

endmodule

// File: rtl/semaforo_peatonal.sv
// Pedestrian-side controller: turns a debounced button press into a
// request pulse for the vehicle controller, then runs the walk / flash /
// clear sequence only while vehicles hold red, latching any interlock fault.
module semaforo_peatonal
    import semaforo_pkg::*;
#(
    parameter int DEBOUNCE     = DEF_DEBOUNCE,
    parameter int WALK_CYCLES  = DEF_WALK_CYCLES,
    parameter int FLASH_CYCLES = DEF_FLASH_CYCLES,
    parameter int BLINK_HALF   = DEF_BLINK_HALF,
    parameter int CW           = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          boton,
    input  logic          rojo,
    input  logic          amarillo,
    input  logic          verde,
    input  logic          blanco,
    output logic          pulsador,
    output logic          peaton_verde,
    output logic          peaton_rojo,
    output logic          espera,
    output logic [CW-1:0] cuenta,
    output logic          falla
);

    localparam logic [CW-1:0] CUENTA_INI = CW'(WALK_CYCLES + FLASH_CYCLES - 1);
    localparam logic [CW-1:0] WALK_FIN   = CW'(WALK_CYCLES - 1);
    localparam logic [CW-1:0] FLASH_FIN  = CW'(FLASH_CYCLES - 1);
    localparam logic [CW-1:0] BLINK_FIN  = CW'(BLINK_HALF - 1);

    estado_t       estado_q;
    logic          pulsador_q;
    logic          peaton_verde_q;
    logic          peaton_rojo_q;
    logic          espera_q;
    logic          falla_q;
    logic          pend_q;
    logic [CW-1:0] cuenta_q;
    logic [CW-1:0] fase_q;
    logic [CW-1:0] blink_q;

    logic nivel;
    logic pulsacion;
    logic press;
    logic violacion;
    logic autorizado;

    antirrebote #(
        .DEBOUNCE(DEBOUNCE)
    ) u_antirrebote (
        .clk_i      (clk),
        .rst_ni     (rst),
        .boton_i    (boton),
        .nivel_o    (nivel),
        .pulsacion_o(pulsacion)
    );

    // The event is only meaningful while the level it announces is high.
    assign press      = pulsacion && nivel;
    assign violacion  = viola_enclavamiento(rojo, amarillo, verde);
    assign autorizado = blanco && !violacion;

    // Phase sequencer with registered lamp, countdown and fault outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q       <= ESPERA;
            pulsador_q     <= 1'b0;
            peaton_verde_q <= 1'b0;
            peaton_rojo_q  <= 1'b1;
            espera_q       <= 1'b0;
            falla_q        <= 1'b0;
            pend_q         <= 1'b0;
            cuenta_q       <= '0;
            fase_q         <= '0;
            blink_q        <= '0;
        end else begin
            pulsador_q <= 1'b0;
            case (estado_q)
                ESPERA: begin
                    if (press || pend_q) begin
                        pulsador_q <= 1'b1;
                        espera_q   <= 1'b1;
                        pend_q     <= 1'b0;
                        estado_q   <= SOLICITUD;
                    end
                end
                SOLICITUD: begin
                    // Presses here are absorbed, including on the entry edge.
                    if (autorizado) begin
                        estado_q       <= CRUCE;
                        peaton_verde_q <= 1'b1;
                        peaton_rojo_q  <= 1'b0;
                        espera_q       <= 1'b0;
                        cuenta_q       <= CUENTA_INI;
                        fase_q         <= WALK_FIN;
                    end
                end
                CRUCE: begin
                    if (press) pend_q <= 1'b1;
                    if (violacion || !blanco) begin
                        estado_q       <= DESPEJE;
                        peaton_verde_q <= 1'b0;
                        peaton_rojo_q  <= 1'b1;
                        cuenta_q       <= '0;
                        if (violacion) falla_q <= 1'b1;
                    end else if (fase_q == '0) begin
                        estado_q       <= PARPADEO;
                        peaton_verde_q <= 1'b1;
                        cuenta_q       <= cuenta_q - 1'b1;
                        fase_q         <= FLASH_FIN;
                        blink_q        <= BLINK_FIN;
                    end else begin
                        cuenta_q <= cuenta_q - 1'b1;
                        fase_q   <= fase_q - 1'b1;
                    end
                end
                PARPADEO: begin
                    if (press) pend_q <= 1'b1;
                    if (violacion || !blanco || fase_q == '0) begin
                        estado_q       <= DESPEJE;
                        peaton_verde_q <= 1'b0;
                        peaton_rojo_q  <= 1'b1;
                        cuenta_q       <= '0;
                        if (violacion) falla_q <= 1'b1;
                    end else begin
                        cuenta_q <= cuenta_q - 1'b1;
                        fase_q   <= fase_q - 1'b1;
                        if (blink_q == '0) begin
                            peaton_verde_q <= ~peaton_verde_q;
                            blink_q        <= BLINK_FIN;
                        end else begin
                            blink_q <= blink_q - 1'b1;
                        end
                    end
                end
                DESPEJE: begin
                    // Wait for the authorisation to drop so it is served once.
                    if (press) pend_q <= 1'b1;
                    if (!blanco) estado_q <= ESPERA;
                end
                default: begin
                    estado_q       <= ESPERA;
                    peaton_verde_q <= 1'b0;
                    peaton_rojo_q  <= 1'b1;
                    espera_q       <= 1'b0;
                    cuenta_q       <= '0;
                end
            endcase
        end
    end

    assign pulsador     = pulsador_q;
    assign peaton_verde = peaton_verde_q;
    assign peaton_rojo  = peaton_rojo_q;
    assign espera       = espera_q;
    assign cuenta       = cuenta_q;
    assign falla        = falla_q;

endmodule

// File: tb/tb_semaforo_peatonal.sv
// Scenario bench for semaforo_peatonal: each scenario queues per-cycle
// stimulus with the expected outputs, then drains the queue cycle by cycle.
module tb_semaforo_peatonal;

    logic       clk = 1'b0;
    logic       rst;
    logic       boton, rojo, amarillo, verde, blanco;
    logic       pulsador, peaton_verde, peaton_rojo, espera, falla;
    logic [7:0] cuenta;
    logic [12:0] obs;

    int checks = 0;
    int errors = 0;

    // Stimulus order: {boton, rojo, amarillo, verde, blanco}
    localparam logic [4:0] S_IDLE = 5'b00000;
    localparam logic [4:0] S_BOT  = 5'b10000;
    localparam logic [4:0] S_ROJO = 5'b01000;
    localparam logic [4:0] S_AUT  = 5'b01001;
    localparam logic [4:0] S_FALT = 5'b01011;
    localparam logic [12:0] M_ALL   = 13'h1fff;
    localparam logic [12:0] M_NOESP = 13'h1dff;

    typedef struct {
        logic [4:0]  stim;
        logic [12:0] val;
        logic [12:0] msk;
    } item_t;

    item_t sb_q[$];

    semaforo_peatonal dut (
        .clk         (clk),
        .rst         (rst),
        .boton       (boton),
        .rojo        (rojo),
        .amarillo    (amarillo),
        .verde       (verde),
        .blanco      (blanco),
        .pulsador    (pulsador),
        .peaton_verde(peaton_verde),
        .peaton_rojo (peaton_rojo),
        .espera      (espera),
        .cuenta      (cuenta),
        .falla       (falla)
    );

    always #5 clk = ~clk;

    assign obs = {pulsador, peaton_verde, peaton_rojo, espera, falla, cuenta};

    function automatic logic [12:0] ev(input logic p, input logic pv, input logic pr,
                                       input logic e, input logic f, input logic [7:0] c);
        return {p, pv, pr, e, f, c};
    endfunction

    task automatic push(input logic [4:0] s, input logic [12:0] v, input logic [12:0] m);
        item_t it;
        it.stim = s;
        it.val  = v;
        it.msk  = m;
        sb_q.push_back(it);
    endtask

    // Hold the button 10 cycles from idle, then release for 8.
    task automatic push_press(input logic f);
        for (int k = 1; k <= 10; k++)
            push(S_BOT, ev(k == 7, 1'b0, 1'b1, k >= 8, f, 8'd0), (k == 7) ? M_NOESP : M_ALL);
        for (int k = 1; k <= 8; k++)
            push(S_IDLE, ev(1'b0, 1'b0, 1'b1, 1'b1, f, 8'd0), M_ALL);
    endtask

    // Full walk + flash from SOLICITUD, optional press during the flash.
    task automatic push_walk(input logic press_flash);
        for (int k = 1; k <= 8; k++)
            push(S_AUT, ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(14 - k)), M_ALL);
        for (int k = 9; k <= 14; k++)
            push(press_flash ? (S_AUT | S_BOT) : S_AUT,
                 ev(1'b0, (k % 2) == 1, 1'b0, 1'b0, 1'b0, 8'(14 - k)), M_ALL);
        push(S_AUT, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), M_ALL);
    endtask

    task automatic test_reset;
        {boton, rojo, amarillo, verde, blanco} = S_IDLE;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs !== ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0)) begin
            errors++;
            $display("FAIL reset_async got=%h want=%h", obs, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (obs !== ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0)) begin
            errors++;
            $display("FAIL reset_held got=%h want=%h", obs, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        end
        #3 rst = 1'b1;
    endtask

    task automatic test_bounce;
        int n = 0;
        item_t it;
        push(S_BOT, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), M_ALL);
        push(S_IDLE, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), M_ALL);
        push(S_BOT, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), M_ALL);
        for (int k = 0; k < 11; k++)
            push(S_IDLE, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), M_ALL);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            {boton, rojo, amarillo, verde, blanco} = it.stim;
            @(posedge clk); #1;
            n++; checks++;
            if ((obs & it.msk) !== (it.val & it.msk)) begin
                errors++;
                $display("FAIL bounce cyc%0d got=%h want=%h mask=%h", n, obs, it.val, it.msk);
            end
        end
    endtask

    task automatic test_press;
        int n = 0;
        item_t it;
        push_press(1'b0);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            {boton, rojo, amarillo, verde, blanco} = it.stim;
            @(posedge clk); #1;
            n++; checks++;
            if ((obs & it.msk) !== (it.val & it.msk)) begin
                errors++;
                $display("FAIL press cyc%0d got=%h want=%h mask=%h", n, obs, it.val, it.msk);
            end
        end
    endtask

    task automatic test_walk;
        int n = 0;
        item_t it;
        push_walk(1'b0);
        push(S_AUT, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), M_ALL);
        push(S_ROJO, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), M_ALL);
        for (int k = 0; k < 3; k++)
            push(S_IDLE, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), M_ALL);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            {boton, rojo, amarillo, verde, blanco} = it.stim;
            @(posedge clk); #1;
            n++; checks++;
            if ((obs & it.msk) !== (it.val & it.msk)) begin
                errors++;
                $display("FAIL walk cyc%0d got=%h want=%h mask=%h", n, obs, it.val, it.msk);
            end
        end
    endtask

    task automatic test_queued;
        int n = 0;
        item_t it;
        push_press(1'b0);
        push_walk(1'b1);
        push(S_AUT, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), M_ALL);
        push(S_AUT, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), M_ALL);
        push(S_ROJO, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), M_ALL);
        push(S_IDLE, ev(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0), M_NOESP);
        for (int k = 0; k < 3; k++)
            push(S_IDLE, ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0), M_ALL);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            {boton, rojo, amarillo, verde, blanco} = it.stim;
            @(posedge clk); #1;
            n++; checks++;
            if ((obs & it.msk) !== (it.val & it.msk)) begin
                errors++;
                $display("FAIL queued cyc%0d got=%h want=%h mask=%h", n, obs, it.val, it.msk);
            end
        end
    endtask

    task automatic test_interlock;
        int n = 0;
        item_t it;
        for (int k = 1; k <= 4; k++)
            push(S_AUT, ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(14 - k)), M_ALL);
        push(S_FALT, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0), M_ALL);
        push(S_ROJO, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0), M_ALL);
        for (int k = 0; k < 4; k++)
            push(S_IDLE, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0), M_ALL);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            {boton, rojo, amarillo, verde, blanco} = it.stim;
            @(posedge clk); #1;
            n++; checks++;
            if ((obs & it.msk) !== (it.val & it.msk)) begin
                errors++;
                $display("FAIL interlock cyc%0d got=%h want=%h mask=%h", n, obs, it.val, it.msk);
            end
        end
    endtask

    task automatic test_reset_midwalk;
        int n = 0;
        item_t it;
        push_press(1'b1);
        push(S_AUT, ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd13), M_ALL);
        for (int k = 2; k <= 6; k++)
            push(S_AUT | S_BOT, ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'(14 - k)), M_ALL);
        for (int k = 7; k <= 8; k++)
            push(S_AUT, ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'(14 - k)), M_ALL);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            {boton, rojo, amarillo, verde, blanco} = it.stim;
            @(posedge clk); #1;
            n++; checks++;
            if ((obs & it.msk) !== (it.val & it.msk)) begin
                errors++;
                $display("FAIL midwalk cyc%0d got=%h want=%h mask=%h", n, obs, it.val, it.msk);
            end
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if (obs !== ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0)) begin
            errors++;
            $display("FAIL midwalk_async_reset got=%h want=%h", obs, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        end
        {boton, rojo, amarillo, verde, blanco} = S_IDLE;
        #1 rst = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++)
            push(S_IDLE, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0), M_ALL);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            {boton, rojo, amarillo, verde, blanco} = it.stim;
            @(posedge clk); #1;
            n++; checks++;
            if ((obs & it.msk) !== (it.val & it.msk)) begin
                errors++;
                $display("FAIL after_reset cyc%0d got=%h want=%h mask=%h", n, obs, it.val, it.msk);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_bounce();
        test_press();
        test_walk();
        test_queued();
        test_interlock();
        test_reset_midwalk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
